// File: rtl/bus_sram_responder_pkg.sv
// rtl/bus_sram_responder_pkg.sv - shared bus types and responder FSM state encoding
// Purpose: word/pointer types used on the core memory bus, plus the
//          responder state enum and wait-counter width.
// Ports:   none (package).
package bus_sram_responder_pkg;

   typedef logic [29:0] ptr;
   typedef logic [31:0] word;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS,
      READY
   } bus_rsp_state;

   localparam int WS_BITS = 4;

endpackage

// File: rtl/bus_sram_responder_if.sv
// rtl/bus_sram_responder_if.sv - single-master memory bus interface
// Purpose: groups the request/response signals of the core memory bus.
// Ports:   bus_addr/bus_start/bus_write/bus_data_wr/bus_data_be (master -> slave),
//          bus_ready/bus_data_rd (slave -> master).
interface bus_sram_responder_if;
   import bus_sram_responder_pkg::*;

   ptr         bus_addr;
   logic       bus_start;
   logic       bus_write;
   word        bus_data_wr;
   logic [3:0] bus_data_be;
   logic       bus_ready;
   word        bus_data_rd;

   modport master (
      output bus_addr, bus_start, bus_write, bus_data_wr, bus_data_be,
      input  bus_ready, bus_data_rd
   );

   modport slave (
      input  bus_addr, bus_start, bus_write, bus_data_wr, bus_data_be,
      output bus_ready, bus_data_rd
   );

endinterface

// File: rtl/bus_sram_responder_bank.sv
// rtl/bus_sram_responder_bank.sv - byte-enabled synchronous single-port SRAM bank
// Purpose: 2^ADDR_BITS x 32 RAM, four byte lanes, registered read output.
// Ports:   clk, rst_n      clock, async active-low reset (read register only)
//          en_i, we_i      access enable, 1 = write
//          addr_i          word index
//          be_i, wdata_i   byte enables and write data
//          rdata_o         registered read data, updated only by reads
module bus_sram_bank #(
   parameter int ADDR_BITS = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic                 we_i,
   input  logic [ADDR_BITS-1:0] addr_i,
   input  logic [3:0]           be_i,
   input  logic [31:0]          wdata_i,
   output logic [31:0]          rdata_o
);

   logic [31:0] mem_q [2**ADDR_BITS];
   logic [31:0] rdata_q;

   // Array contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Read register holds its value across writes and idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (en_i && !we_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_sram_responder.sv
// rtl/bus_sram_responder.sv - memory bus target serving requests from on-chip SRAM
// Purpose: accepts one bus transaction at a time, inserts WAIT_STATES idle
//          cycles, performs the SRAM access and pulses bus_ready.
// Ports:   clk, rst_n   clock, async active-low reset
//          bus          slave side of the memory bus
//          oob          sticky out-of-window access flag
//          busy         transaction in flight (through the bus_ready cycle)
module bus_sram_responder
   import bus_sram_responder_pkg::*;
#(
   parameter int          ADDR_BITS   = 12,
   parameter logic [29:0] BASE        = 30'd0,
   parameter int          WAIT_STATES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bus_sram_responder_if.slave  bus,
   output logic                 oob,
   output logic                 busy
);

   bus_rsp_state         state_q, state_d;
   logic [WS_BITS-1:0]   cnt_q, cnt_d;
   ptr                   addr_q, addr_d;
   logic                 write_q, write_d;
   word                  wdata_q, wdata_d;
   logic [3:0]           be_q, be_d;
   logic                 oob_q, oob_d;
   logic                 rd_zero_q, rd_zero_d;
   logic                 mem_en;
   ptr                   offset;
   logic                 in_win;
   word                  bank_rdata;

   // Window decode wraps modulo 2^30, so addresses below BASE fall out too.
   assign offset = addr_q - BASE;
   assign in_win = (offset >> ADDR_BITS) == '0;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      oob_d     = oob_q;
      rd_zero_d = rd_zero_q;
      mem_en    = 1'b0;
      case (state_q)
         IDLE, READY: begin
            if (state_q == READY) state_d = IDLE;
            // READY accepts a new start so back-to-back requests lose no cycle.
            if (bus.bus_start) begin
               addr_d  = bus.bus_addr;
               write_d = bus.bus_write;
               wdata_d = bus.bus_data_wr;
               be_d    = bus.bus_data_be;
               cnt_d   = WS_BITS'(WAIT_STATES);
               state_d = (WAIT_STATES > 0) ? WAIT : ACCESS;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= 1) state_d = ACCESS;
         end
         ACCESS: begin
            mem_en = in_win;
            // Out-of-window reads must return zero without disturbing the
            // bank read register, so the zero is applied at the output mux.
            if (!write_q) rd_zero_d = !in_win;
            if (!in_win) oob_d = 1'b1;
            state_d = READY;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         be_q      <= '0;
         oob_q     <= 1'b0;
         rd_zero_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         oob_q     <= oob_d;
         rd_zero_q <= rd_zero_d;
      end
   end

   bus_sram_bank #(
      .ADDR_BITS (ADDR_BITS)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (mem_en),
      .we_i    (write_q),
      .addr_i  (offset[ADDR_BITS-1:0]),
      .be_i    (be_q),
      .wdata_i (wdata_q),
      .rdata_o (bank_rdata)
   );

   assign bus.bus_ready   = (state_q == READY);
   assign bus.bus_data_rd = rd_zero_q ? '0 : bank_rdata;
   assign oob             = oob_q;
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_bus_sram_responder.sv
// tb/tb_bus_sram_responder.sv - scoreboard bench for bus_sram_responder
module tb_bus_sram_responder;
   import bus_sram_responder_pkg::*;

   typedef struct {
      string name;
      bit    chk;
      word   data;
      int    cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic oob1, busy1, oob0, busy0;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t q1[$];
   exp_t q0[$];

   bus_sram_responder_if b1 ();
   bus_sram_responder_if b0 ();

   bus_sram_responder #(.ADDR_BITS(12), .BASE(30'd0), .WAIT_STATES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1), .oob(oob1), .busy(busy1));

   bus_sram_responder #(.ADDR_BITS(12), .BASE(30'd0), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(b0), .oob(oob0), .busy(busy0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin : mon1
      exp_t e;
      if (b1.bus_ready === 1'b1) begin
         if (q1.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dut1 unexpected bus_ready: got 1 at cycle %0d, expected 0", cyc);
         end else begin
            e = q1.pop_front();
            check({e.name, " cycle"}, cyc, e.cyc);
            check({e.name, " busy"}, busy1, 1);
            if (e.chk) check({e.name, " data"}, b1.bus_data_rd, e.data);
         end
      end
   end

   always @(negedge clk) begin : mon0
      exp_t e;
      if (b0.bus_ready === 1'b1) begin
         if (q0.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL dut0 unexpected bus_ready: got 1 at cycle %0d, expected 0", cyc);
         end else begin
            e = q0.pop_front();
            check({e.name, " cycle"}, cyc, e.cyc);
            if (e.chk) check({e.name, " data"}, b0.bus_data_rd, e.data);
         end
      end
   end

   // Raise bus_start on one DUT and optionally record the expected response.
   task automatic drive(input bit d0, input ptr a, input bit w, input word d,
                        input logic [3:0] be, input bit push, input bit chk,
                        input word exp, input string nm);
      exp_t e;
      if (d0) begin
         b0.bus_addr = a; b0.bus_write = w; b0.bus_data_wr = d;
         b0.bus_data_be = be; b0.bus_start = 1'b1;
      end else begin
         b1.bus_addr = a; b1.bus_write = w; b1.bus_data_wr = d;
         b1.bus_data_be = be; b1.bus_start = 1'b1;
      end
      if (push) begin
         e.name = nm; e.chk = chk; e.data = exp;
         e.cyc = cyc + (d0 ? 2 : 3);
         if (d0) q0.push_back(e);
         else    q1.push_back(e);
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         if (q1.size() == 0 && q0.size() == 0) break;
         @(negedge clk);
      end
      if (q1.size() != 0 || q0.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: got %0d/%0d responses pending, expected 0",
                  q1.size(), q0.size());
         q1.delete();
         q0.delete();
      end
      @(negedge clk);
   endtask

   task automatic txn(input ptr a, input bit w, input word d, input logic [3:0] be,
                      input bit chk, input word exp, input string nm);
      drive(1'b0, a, w, d, be, 1'b1, chk, exp, nm);
      @(negedge clk);
      b1.bus_start = 1'b0;
      wait_done();
   endtask

   word vals[4];

   initial begin
      vals = '{32'h0123_4567, 32'h89AB_CDEF, 32'hA5A5_5A5A, 32'h0F0F_F0F0};
      b1.bus_addr = '0; b1.bus_start = 1'b0; b1.bus_write = 1'b0;
      b1.bus_data_wr = '0; b1.bus_data_be = '0;
      b0.bus_addr = '0; b0.bus_start = 1'b0; b0.bus_write = 1'b0;
      b0.bus_data_wr = '0; b0.bus_data_be = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("reset ready", b1.bus_ready, 0);
      check("reset data_rd", b1.bus_data_rd, 0);
      check("reset oob", oob1, 0);
      check("reset busy", busy1, 0);

      // Basic write/read with one wait state
      txn(30'd5, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, '0, "wr5");
      txn(30'd5, 1'b0, '0, 4'hF, 1'b1, 32'hCAFE_F00D, "rd5");

      // Byte lanes
      txn(30'd5, 1'b1, 32'h1122_3344, 4'b0101, 1'b0, '0, "wr5 be0101");
      txn(30'd5, 1'b0, '0, 4'h0, 1'b1, 32'hCA22_F044, "rd5 lanes");
      txn(30'd5, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b0, '0, "wr5 be0");
      check("data_rd held after write", b1.bus_data_rd, 32'hCA22_F044);
      txn(30'd5, 1'b0, '0, 4'hF, 1'b1, 32'hCA22_F044, "rd5 after be0");

      // Back-to-back on the zero-wait-state instance
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ptr'(10 + i), 1'b1, vals[i], 4'hF, 1'b1, 1'b0, '0, "b2b wr");
         @(negedge clk);
         b0.bus_start = 1'b0;
         @(negedge clk);
      end
      wait_done();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, ptr'(10 + i), 1'b0, '0, 4'hF, 1'b1, 1'b1, vals[i], "b2b rd");
         @(negedge clk);
         b0.bus_start = 1'b0;
         @(negedge clk);
      end
      wait_done();
      check("dut0 oob clear", oob0, 0);

      // Out of window
      txn(30'd0, 1'b1, 32'h1234_5678, 4'hF, 1'b0, '0, "wr0");
      check("oob before", oob1, 0);
      txn(30'h1000, 1'b0, '0, 4'hF, 1'b1, 32'h0, "rd oob");
      check("oob set", oob1, 1);
      txn(30'h1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, '0, "wr oob");
      txn(30'd0, 1'b0, '0, 4'hF, 1'b1, 32'h1234_5678, "rd0 after oob wr");
      check("oob sticky", oob1, 1);

      // Start during a busy transaction is ignored
      drive(1'b0, 30'd5, 1'b0, '0, 4'hF, 1'b1, 1'b1, 32'hCA22_F044, "rd5 busy");
      @(negedge clk);
      drive(1'b0, 30'd5, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0, '0, "ignored");
      @(negedge clk);
      b1.bus_start = 1'b0;
      wait_done();
      repeat (4) @(negedge clk);
      txn(30'd5, 1'b0, '0, 4'hF, 1'b1, 32'hCA22_F044, "rd5 after ignored");

      // Reset during WAIT of a write
      txn(30'd7, 1'b1, 32'h0, 4'hF, 1'b0, '0, "wr7 zero");
      drive(1'b0, 30'd7, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, '0, "wr7 aborted");
      @(negedge clk);
      b1.bus_start = 1'b0;
      check("busy in wait", busy1, 1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst ready", b1.bus_ready, 0);
      check("rst data_rd", b1.bus_data_rd, 0);
      check("rst oob", oob1, 0);
      check("rst busy", busy1, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      txn(30'd7, 1'b0, '0, 4'hF, 1'b1, 32'h0, "rd7 after reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
